// File: rtl/hs_monitor_pkg.sv
// Shared types and helpers for the handshake protocol monitor.
// Error kinds double as bit positions within each channel's 6-bit error field.
package hs_monitor_pkg;

    localparam int NUM_ERR = 6;

    typedef enum logic [2:0] {
        ERR_LATE         = 3'd0,
        ERR_EARLY        = 3'd1,
        ERR_REQ_DROP     = 3'd2,
        ERR_SPURIOUS_ACK = 3'd3,
        ERR_VALID_DROP   = 3'd4,
        ERR_DATA_CHANGE  = 3'd5
    } err_kind_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RELEASE
    } hs_state_e;

    function automatic logic [2:0] popcount6(input logic [NUM_ERR-1:0] bits);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_ERR; i++) begin
            n = n + {2'b00, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hs_channel_checker.sv
// One channel of the monitor: req/ack handshake FSM, valid/ready stream checks,
// sticky error flags and a saturating error counter.
module hs_channel_checker
    import hs_monitor_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 10,
    parameter int COUNT_W = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               request,
    input  logic               acknowledge,
    input  logic               valid,
    input  logic               ready,
    input  logic [DATA_W-1:0]  data,
    input  logic               clear,
    output logic [NUM_ERR-1:0] err_pulse,
    output logic [NUM_ERR-1:0] err_sticky,
    output logic [COUNT_W-1:0] err_count,
    output logic [LAT_W-1:0]   lat_last
);

    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

    hs_state_e          state;
    logic [LAT_W-1:0]   lat;
    logic               late_hold;
    logic               prev_valid;
    logic               prev_ready;
    logic [DATA_W-1:0]  prev_data;
    logic [NUM_ERR-1:0] detect;
    logic [COUNT_W-1:0] count_base;
    logic [COUNT_W+2:0] count_sum;
    logic [COUNT_W-1:0] count_next;

    always_comb begin
        detect = '0;
        case (state)
            IDLE: begin
                detect[ERR_SPURIOUS_ACK] = acknowledge && !request;
            end
            WAIT_ACK: begin
                detect[ERR_REQ_DROP] = !request;
                detect[ERR_EARLY]    = request && acknowledge && (lat < MIN_L);
                detect[ERR_LATE]     = request && !acknowledge && (lat == MAX_L);
            end
            default: ;
        endcase
        // A stalled beat (valid without ready) must hold both valid and data.
        if (prev_valid && !prev_ready) begin
            detect[ERR_VALID_DROP]  = !valid;
            detect[ERR_DATA_CHANGE] = valid && (data != prev_data);
        end
    end

    // Sum is three bits wider than the counter so a popcount of up to six never wraps.
    always_comb begin
        count_base = clear ? '0 : err_count;
        count_sum  = {3'b000, count_base} + {{COUNT_W{1'b0}}, popcount6(detect)};
        count_next = (count_sum > {3'b000, {COUNT_W{1'b1}}}) ? '1 : count_sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat        <= '0;
            late_hold  <= 1'b0;
            lat_last   <= '0;
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_data  <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
            err_count  <= '0;
        end else begin
            if (!request) begin
                late_hold <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (request && !late_hold) begin
                        state <= WAIT_ACK;
                        lat   <= LAT_W'(1);
                    end
                end
                WAIT_ACK: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (acknowledge) begin
                        lat_last <= lat;
                        state    <= RELEASE;
                    end else if (lat == MAX_L) begin
                        // Timed out: stay disarmed until request has gone low once.
                        state     <= IDLE;
                        late_hold <= 1'b1;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!request && !acknowledge) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            prev_valid <= valid;
            prev_ready <= ready;
            prev_data  <= data;
            err_pulse  <= detect;
            err_sticky <= clear ? detect : (err_sticky | detect);
            err_count  <= count_next;
        end
    end

endmodule

// File: rtl/hs_protocol_monitor.sv
// Passive multi-channel handshake protocol monitor: one checker per channel
// and a masked interrupt over all sticky error flags.
module hs_protocol_monitor
    import hs_monitor_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 10,
    parameter int COUNT_W = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         request,
    input  logic [NUM_CH-1:0]         acknowledge,
    input  logic [NUM_CH-1:0]         valid,
    input  logic [NUM_CH-1:0]         ready,
    input  logic [NUM_CH*DATA_W-1:0]  data,
    input  logic [NUM_ERR-1:0]        err_mask,
    input  logic                      clear,
    output logic [NUM_CH*NUM_ERR-1:0] err_pulse,
    output logic [NUM_CH*NUM_ERR-1:0] err_sticky,
    output logic [NUM_CH*COUNT_W-1:0] err_count,
    output logic [NUM_CH*LAT_W-1:0]   lat_last,
    output logic                      irq
);

    logic [NUM_CH*NUM_ERR-1:0] masked;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        hs_channel_checker #(
            .DATA_W  (DATA_W),
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT),
            .COUNT_W (COUNT_W),
            .LAT_W   (LAT_W)
        ) u_checker (
            .clk         (clk),
            .rst         (rst),
            .request     (request[ch]),
            .acknowledge (acknowledge[ch]),
            .valid       (valid[ch]),
            .ready       (ready[ch]),
            .data        (data[ch*DATA_W +: DATA_W]),
            .clear       (clear),
            .err_pulse   (err_pulse[ch*NUM_ERR +: NUM_ERR]),
            .err_sticky  (err_sticky[ch*NUM_ERR +: NUM_ERR]),
            .err_count   (err_count[ch*COUNT_W +: COUNT_W]),
            .lat_last    (lat_last[ch*LAT_W +: LAT_W])
        );

        assign masked[ch*NUM_ERR +: NUM_ERR] = err_sticky[ch*NUM_ERR +: NUM_ERR] & err_mask;
    end

    assign irq = |masked;

endmodule

// File: tb/tb_hs_protocol_monitor.sv
// Bench for hs_protocol_monitor: a default two-channel instance plus a one-channel
// instance with MIN_LAT=3/MAX_LAT=6 so EARLY and fast LATE saturation are reachable.
module tb_hs_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req_a, ack_a, val_a, rdy_a;
    logic [15:0] data_a;
    logic [5:0]  mask_a;
    logic        clr_a;
    logic [11:0] pulse_a, sticky_a;
    logic [15:0] count_a;
    logic [7:0]  lat_a;
    logic        irq_a;

    logic        req_b, ack_b, val_b, rdy_b;
    logic [7:0]  data_b;
    logic [5:0]  mask_b;
    logic        clr_b;
    logic [5:0]  pulse_b, sticky_b;
    logic [7:0]  count_b;
    logic [2:0]  lat_b;
    logic        irq_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state, indices 0/1 = instance A channels, 2 = instance B channel.
    int         m_phase[3];
    int         m_start[3];
    bit         m_hold[3];
    bit         m_pv[3];
    bit         m_pr[3];
    logic [7:0] m_pd[3];
    logic [5:0] m_pulse[3];
    logic [5:0] m_sticky[3];
    int         m_count[3];
    int         m_lat[3];

    hs_protocol_monitor dut_a (
        .clk(clk), .rst(rst), .request(req_a), .acknowledge(ack_a),
        .valid(val_a), .ready(rdy_a), .data(data_a), .err_mask(mask_a),
        .clear(clr_a), .err_pulse(pulse_a), .err_sticky(sticky_a),
        .err_count(count_a), .lat_last(lat_a), .irq(irq_a)
    );

    hs_protocol_monitor #(.NUM_CH(1), .MIN_LAT(3), .MAX_LAT(6)) dut_b (
        .clk(clk), .rst(rst), .request(req_b), .acknowledge(ack_b),
        .valid(val_b), .ready(rdy_b), .data(data_b), .err_mask(mask_b),
        .clear(clr_b), .err_pulse(pulse_b), .err_sticky(sticky_b),
        .err_count(count_b), .lat_last(lat_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = 0; m_start[k] = 0; m_hold[k] = 0;
            m_pv[k] = 0; m_pr[k] = 0; m_pd[k] = '0;
            m_pulse[k] = '0; m_sticky[k] = '0; m_count[k] = 0; m_lat[k] = 0;
        end
    endtask

    // Phase 0 idle, 1 waiting for ack, 2 waiting for release; latency is elapsed cycles since request rose.
    task automatic model_step(input int k, input int mn, input int mx,
                              input logic r, input logic a, input logic v, input logic rd,
                              input logic [7:0] d, input logic clr);
        logic [5:0] det;
        int waited;
        det = '0;
        if (!r) m_hold[k] = 0;
        if (m_phase[k] == 0) begin
            if (r && !m_hold[k]) begin
                m_phase[k] = 1;
                m_start[k] = cyc;
            end else if (a && !r) begin
                det[3] = 1'b1;
            end
        end else if (m_phase[k] == 1) begin
            waited = cyc - m_start[k];
            if (!r) begin
                det[2] = 1'b1;
                m_phase[k] = 0;
            end else if (a) begin
                m_lat[k] = waited;
                if (waited < mn) det[1] = 1'b1;
                m_phase[k] = 2;
            end else if (waited >= mx) begin
                det[0] = 1'b1;
                m_phase[k] = 0;
                m_hold[k] = 1;
            end
        end else if (!r && !a) begin
            m_phase[k] = 0;
        end
        if (m_pv[k] && !m_pr[k]) begin
            if (!v) det[4] = 1'b1;
            else if (d != m_pd[k]) det[5] = 1'b1;
        end
        m_pv[k] = v; m_pr[k] = rd; m_pd[k] = d;
        m_pulse[k]  = det;
        m_sticky[k] = clr ? det : (m_sticky[k] | det);
        m_count[k]  = (clr ? 0 : m_count[k]) + $countones(det);
        if (m_count[k] > 255) m_count[k] = 255;
    endtask

    always @(posedge clk) begin
        logic exp_irq;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                model_step(c, 1, 10, req_a[c], ack_a[c], val_a[c], rdy_a[c], data_a[c*8 +: 8], clr_a);
            end
            model_step(2, 3, 6, req_b, ack_b, val_b, rdy_b, data_b, clr_b);
        end
        cyc++;
        #1;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("a%0d pulse", c),  32'(pulse_a[c*6 +: 6]),  32'(m_pulse[c]));
            check($sformatf("a%0d sticky", c), 32'(sticky_a[c*6 +: 6]), 32'(m_sticky[c]));
            check($sformatf("a%0d count", c),  32'(count_a[c*8 +: 8]),  m_count[c]);
            check($sformatf("a%0d lat", c),    32'(lat_a[c*4 +: 4]),    m_lat[c]);
        end
        exp_irq = |((m_sticky[0] | m_sticky[1]) & mask_a);
        check("a irq", 32'(irq_a), 32'(exp_irq));
        check("b pulse",  32'(pulse_b),  32'(m_pulse[2]));
        check("b sticky", 32'(sticky_b), 32'(m_sticky[2]));
        check("b count",  32'(count_b),  m_count[2]);
        check("b lat",    32'(lat_b),    m_lat[2]);
        exp_irq = |(m_sticky[2] & mask_b);
        check("b irq", 32'(irq_b), 32'(exp_irq));
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; ack_a = '0; val_a = '0; rdy_a = '0; data_a = '0; mask_a = '0; clr_a = 1'b0;
        req_b = 1'b0; ack_b = 1'b0; val_b = 1'b0; rdy_b = 1'b0; data_b = '0; mask_b = '0; clr_b = 1'b0;
        applyStimulus(3);
        check("reset count", 32'(count_a), 32'h0);
        check("reset sticky", 32'(sticky_a), 32'h0);
        rst = 1'b0;
        applyStimulus(2);

        // Clean handshake on A ch0 with a two-cycle latency.
        req_a[0] = 1'b1;
        applyStimulus(2);
        ack_a[0] = 1'b1;
        applyStimulus(1);
        check("hs lat_last", 32'(lat_a[3:0]), 32'd2);
        check("hs no pulse", 32'(pulse_a), 32'h0);
        req_a[0] = 1'b0; ack_a[0] = 1'b0;
        applyStimulus(2);

        // Timeout on A ch1; request stays high a few cycles after LATE without re-arming.
        mask_a = 6'b000001;
        req_a[1] = 1'b1;
        applyStimulus(11);
        check("late pulse", 32'(pulse_a[11:6]), 32'h01);
        check("late count", 32'(count_a[15:8]), 32'd1);
        check("late irq on", 32'(irq_a), 32'd1);
        mask_a = 6'b000000;
        #1;
        check("late irq off", 32'(irq_a), 32'd0);
        applyStimulus(4);
        req_a[1] = 1'b0;
        applyStimulus(2);

        // Request drop then spurious acknowledge on A ch0.
        req_a[0] = 1'b1;
        applyStimulus(1);
        req_a[0] = 1'b0;
        applyStimulus(1);
        check("reqdrop pulse", 32'(pulse_a[5:0]), 32'h04);
        ack_a[0] = 1'b1;
        applyStimulus(1);
        check("spurious pulse", 32'(pulse_a[5:0]), 32'h08);
        ack_a[0] = 1'b0;
        check("ch0 count", 32'(count_a[7:0]), 32'd2);
        check("ch0 sticky", 32'(sticky_a[5:0]), 32'h0C);
        applyStimulus(2);

        // Accepted beats with changing data are legal; then a stalled beat changes and drops.
        val_a[1] = 1'b1; rdy_a[1] = 1'b1; data_a[15:8] = 8'h11;
        applyStimulus(1);
        data_a[15:8] = 8'h22;
        applyStimulus(1);
        rdy_a[1] = 1'b0; data_a[15:8] = 8'hA5;
        applyStimulus(1);
        data_a[15:8] = 8'h5A;
        applyStimulus(1);
        check("datachg pulse", 32'(pulse_a[11:6]), 32'h20);
        val_a[1] = 1'b0;
        applyStimulus(1);
        check("vdrop pulse", 32'(pulse_a[11:6]), 32'h10);
        check("vdrop ch0 quiet", 32'(pulse_a[5:0]), 32'h0);
        check("ch1 count", 32'(count_a[15:8]), 32'd3);
        applyStimulus(2);

        // 300 timeouts on B saturate its counter.
        for (int i = 0; i < 300; i++) begin
            req_b = 1'b1;
            applyStimulus(7);
            req_b = 1'b0;
            applyStimulus(1);
        end
        check("sat count", 32'(count_b), 32'd255);

        // EARLY detected in the same cycle as clear survives the clear.
        mask_b = 6'b000010;
        req_b = 1'b1;
        applyStimulus(1);
        ack_b = 1'b1; clr_b = 1'b1;
        applyStimulus(1);
        clr_b = 1'b0;
        check("early sticky", 32'(sticky_b), 32'h02);
        check("early count", 32'(count_b), 32'd1);
        check("early lat", 32'(lat_b), 32'd1);
        check("early irq", 32'(irq_b), 32'd1);
        req_b = 1'b0; ack_b = 1'b0;
        applyStimulus(2);

        // Reset while A ch0 is waiting at latency 5.
        mask_a = 6'b111111;
        #1;
        check("pre-reset irq", 32'(irq_a), 32'd1);
        req_a[0] = 1'b1;
        applyStimulus(5);
        rst = 1'b1;
        req_a[0] = 1'b0;
        #1;
        check("rst sticky", 32'(sticky_a), 32'h0);
        check("rst count", 32'(count_a), 32'h0);
        check("rst lat", 32'(lat_a), 32'h0);
        check("rst pulse", 32'(pulse_a), 32'h0);
        check("rst irq", 32'(irq_a), 32'd0);
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(12);
        check("post-rst sticky", 32'(sticky_a), 32'h0);
        check("post-rst count", 32'(count_a), 32'h0);
        applyStimulus(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
